// File: rtl/alu_share_ctrl.sv
// Round-robin share of one 32-bit ALU between two valid/ready requesters; 1-cycle accept-to-response, II=2.
// Response is held stable under rsp_ready backpressure. Define ALU_SHARE_FIXED_PRIO_EN for fixed req0 priority.
module alu_share_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_op,
    input  logic [6:0]       req0_funct7,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_op,
    input  logic [6:0]       req1_funct7,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q;
    logic [31:0]        a_q, b_q;
    logic [2:0]         op_q;
    logic [6:0]         f7_q;
    logic [TAG_W-1:0]   tag_q;
    logic               id_q;
    logic               rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [31:0]        rsp_result_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    logic               gnt1, accept;
    logic [31:0]        alu_res_d;
    logic               alu_err_d;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign gnt1 = req1_valid & ~req0_valid;
`else
    logic last_grant_q;
    // On a tie, serve whichever requester was not granted last.
    assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

    assign accept = rst_n & (req0_valid | req1_valid)
                  & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
    assign req0_ready = accept & ~gnt1;
    assign req1_ready = accept & gnt1;

    always_comb begin
        alu_res_d = 32'd0;
        alu_err_d = 1'b0;
        case (op_q)
            3'b000: begin
                if (f7_q == 7'h00)      alu_res_d = a_q + b_q;
                else if (f7_q == 7'h20) alu_res_d = a_q - b_q;
                else                    alu_err_d = 1'b1;
            end
            3'b001:  alu_res_d = a_q << b_q[4:0];
            3'b010:  alu_res_d = {31'd0, $signed(a_q) < $signed(b_q)};
            3'b011:  alu_res_d = {31'd0, a_q < b_q};
            3'b100:  alu_res_d = a_q ^ b_q;
            3'b101:  alu_res_d = a_q >> b_q[4:0];
            3'b110:  alu_res_d = a_q | b_q;
            default: alu_res_d = a_q & b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            f7_q         <= '0;
            tag_q        <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if (accept) begin
                a_q   <= gnt1 ? req1_a      : req0_a;
                b_q   <= gnt1 ? req1_b      : req0_b;
                op_q  <= gnt1 ? req1_op     : req0_op;
                f7_q  <= gnt1 ? req1_funct7 : req0_funct7;
                tag_q <= gnt1 ? req1_tag    : req0_tag;
                id_q  <= gnt1;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                last_grant_q <= gnt1;
`endif
            end
            case (state_q)
                IDLE: if (accept) state_q <= EXEC;
                EXEC: begin
                    rsp_result_q <= alu_res_d;
                    rsp_err_q    <= alu_err_d;
                    rsp_id_q     <= id_q;
                    rsp_tag_q    <= tag_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= accept ? EXEC : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed plus randomized checks of alu_share_ctrl against a transaction-level model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v[2];
    logic [31:0] a[2], b[2];
    logic [2:0]  op[2];
    logic [6:0]  f7[2];
    logic [3:0]  tag[2];
    logic        rsp_ready = 1'b0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;

    int vectors = 0;
    int miscompares = 0;
    int last = 1;

    always #5 clk = ~clk;

    alu_share_ctrl #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(a[0]), .req0_b(b[0]),
        .req0_op(op[0]), .req0_funct7(f7[0]), .req0_tag(tag[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(a[1]), .req1_b(b[1]),
        .req1_op(op[1]), .req1_funct7(f7[1]), .req1_tag(tag[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    function automatic logic [32:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] o, input logic [6:0] f);
        case (o)
            3'd0: begin
                if (f == 7'h00) return {1'b0, x + y};
                if (f == 7'h20) return {1'b0, x - y};
                return {1'b1, 32'd0};
            end
            3'd1: return {1'b0, x << (y % 32)};
            3'd2: return {32'd0, int'(x) < int'(y)};
            3'd3: return {32'd0, x < y};
            3'd4: return {1'b0, x ^ y};
            3'd5: return {1'b0, x >> (y % 32)};
            3'd6: return {1'b0, x | y};
            default: return {1'b0, x & y};
        endcase
    endfunction

    function automatic int pick(input logic p0, input logic p1);
        if (p0 && !p1) return 0;
        if (p1 && !p0) return 1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] o, input logic [6:0] f, input logic [3:0] t);
        a[i] = x; b[i] = y; op[i] = o; f7[i] = f; tag[i] = t;
    endtask

    task automatic rand_req(input int i);
        int r;
        r = $urandom_range(0, 3);
        set_req(i, $urandom, (r == 3) ? 32'($urandom_range(0, 40)) : $urandom,
                3'($urandom), (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom), 4'($urandom));
    endtask

    task automatic rsp_chk(input string name, input logic [32:0] er, input int w, input logic [3:0] et);
        chk({name, "_vld"}, rsp_valid, 1);
        chk({name, "_res"}, rsp_result, er[31:0]);
        chk({name, "_err"}, rsp_err, er[32]);
        chk({name, "_id"}, rsp_id, w);
        chk({name, "_tag"}, rsp_tag, et);
        chk({name, "_busy"}, busy, 1);
    endtask

    // Entered at posedge+1 in IDLE with request inputs set; leaves at posedge+1 back in IDLE.
    task automatic txn(input string name, input int stall);
        int w;
        logic [32:0] er;
        logic [3:0] et;
        #1;
        w = pick(v[0], v[1]);
        chk({name, "_rdy0"}, req0_ready, w == 0);
        chk({name, "_rdy1"}, req1_ready, w == 1);
        er = ref_alu(a[w], b[w], op[w], f7[w]);
        et = tag[w];
        last = w;
        @(posedge clk); #1;
        v[0] = 0; v[1] = 0;
        rand_req(0); rand_req(1);
        rsp_ready = (stall == 0);
        #1;
        chk({name, "_exec_busy"}, busy, 1);
        chk({name, "_exec_vld"}, rsp_valid, 0);
        chk({name, "_exec_rdy"}, {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rsp_chk(name, er, w, et);
        for (int s = 0; s < stall; s++) begin
            v[0] = 1'($urandom); v[1] = 1'($urandom);
            #1;
            chk({name, "_stall_rdy"}, {req0_ready, req1_ready}, 0);
            @(posedge clk); #1;
            rsp_chk({name, "_hold"}, er, w, et);
        end
        v[0] = 0; v[1] = 0; rsp_ready = 1;
        @(posedge clk); #1;
        chk({name, "_done_vld"}, rsp_valid, 0);
        chk({name, "_done_busy"}, busy, 0);
    endtask

    initial begin
        int w;
        logic [32:0] er;
        logic [3:0] et;

        // Reset state, with requests pending to prove ready stays low.
        v[0] = 1; v[1] = 1;
        rand_req(0); rand_req(1);
        #2;
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_res", rsp_result, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        v[0] = 0; v[1] = 0; rsp_ready = 1; rst_n = 1;
        @(posedge clk); #1;

        v[0] = 1; set_req(0, 5, 7, 3'b000, 7'h00, 4'd3);
        txn("add", 0);
        v[1] = 1; set_req(1, 3, 5, 3'b000, 7'h20, 4'd9);
        txn("sub", 0);
        v[1] = 1; set_req(1, 3, 5, 3'b000, 7'h01, 4'd2);
        txn("illegal", 0);

        // Both requesters held valid for four back-to-back transactions.
        v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
        for (int k = 0; k < 4; k++) begin
            #1;
            w = pick(1, 1);
`ifdef ALU_SHARE_FIXED_PRIO_EN
            chk("tie_seq", w, 0);
`else
            chk("tie_seq", w, k % 2);
`endif
            chk("tie_rdy0", req0_ready, w == 0);
            chk("tie_rdy1", req1_ready, w == 1);
            er = ref_alu(a[w], b[w], op[w], f7[w]);
            et = tag[w];
            last = w;
            @(posedge clk); #1;
            rand_req(0); rand_req(1);
            #1;
            chk("tie_exec_vld", rsp_valid, 0);
            @(posedge clk); #1;
            rsp_chk("tie", er, w, et);
        end
        v[0] = 0; v[1] = 0;
        @(posedge clk); #1;
        chk("tie_idle", busy, 0);

        v[0] = 1; set_req(0, 32'hFFFF_FFFF, 1, 3'b010, 7'h00, 4'd5);
        txn("slt_bp", 5);
        v[0] = 1; set_req(0, 1, 32'h21, 3'b001, 7'h00, 4'd6);
        txn("sll", 0);
        v[1] = 1; set_req(1, 32'h8000_0000, 31, 3'b101, 7'h00, 4'd7);
        txn("srl", 0);

        // Reset pulse while the request is in EXEC.
        v[1] = 1; set_req(1, 11, 22, 3'b000, 7'h00, 4'd1);
        #1;
        chk("rstmid_rdy1", req1_ready, 1);
        @(posedge clk); #1;
        v[0] = 1; v[1] = 1;
        rst_n = 0;
        #1;
        chk("rstmid_vld", rsp_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rdy", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        chk("rstmid_vld2", rsp_valid, 0);
        rst_n = 1;
        last = 1;
        rand_req(0); rand_req(1);
        txn("rstmid_tie", 0);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(1, 3);
            v[0] = r[0]; v[1] = r[1];
            rand_req(0); rand_req(1);
            txn("rand", $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shares one instance of the team's combinational `alu` between two requesters (e.g. the execute stage and the address-generation unit) with valid/ready handshakes on both sides. A small state machine arbitrates round-robin, registers operands, runs the ALU for one cycle and holds a registered, tagged response until it is consumed. It sits between the issue logic and writeback.

## Interface
- `TAG_W`, default 4: width of the opaque request tag returned with each result.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `reqN_a`, `reqN_b`  in  32  operands.
- `reqN_op`  in  3  ALU op (funct3 encoding).
- `reqN_funct7`  in  7  ALU funct7.
- `reqN_tag`  in  TAG_W  returned unchanged in `rsp_tag`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  ALU result.
- `rsp_id`  out  1  index of the requester served.
- `rsp_tag`  out  TAG_W  tag of the served request.
- `rsp_err`  out  1  op was 000 with funct7 not 0x00 or 0x20.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if either valid is high, arbitrate, assert the winner's ready, capture a/b/op/funct7/tag/id into operand registers, then go to EXEC. Otherwise stay in IDLE.
- EXEC: the ALU is driven from the operand registers.
  - Register `rsp_result`, `rsp_id`, `rsp_tag` and `rsp_err`, set `rsp_valid` to 1, and go to RESP.
  - Requests are not accepted in EXEC.
- RESP: hold `rsp_valid` and all response fields stable until `rsp_ready` is high.
  - On the handshake cycle, if either request is valid, arbitrate and accept in that same cycle, then go to EXEC with `rsp_valid` falling.
  - If no request is valid, go to IDLE.
- Arbitration: round-robin on the `last_grant` register.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than `last_grant` wins.
  - `last_grant` updates only on an accepted request.
- `reqN_ready` = (IDLE, or RESP with `rsp_ready`) and the grant goes to N. Ready is never high for both requesters, and is never high while the requester's valid is low.
- ALU function set (32-bit, wrap-around):
  - op 000: funct7 0x00 gives ADD, funct7 0x20 gives SUB, any other funct7 gives result 0 with `rsp_err`=1.
  - 001 SLL by b[4:0]; 010 SLT signed (result 0/1); 011 SLTU; 100 XOR; 101 SRL logical; 110 OR; 111 AND.
  - `rsp_err` is 0 for every op other than 000.
- Requester inputs are sampled only on the accept cycle. Later changes have no effect.

## Timing
- Accept at edge N; `rsp_valid` is high after edge N+1. Latency from accept to response is 1 cycle.
- Minimum initiation interval is 2 cycles, reached with `rsp_ready` tied high and continuous requests.
- Reset values:
  - State IDLE, `last_grant`=1 (req0 wins the first tie).
  - `rsp_valid`, `rsp_result`, `rsp_id`, `rsp_tag`, `rsp_err` and `busy` all 0.
  - Both ready outputs 0 while `rst_n` is low.
- Reset asserted mid-transaction aborts it. No response is produced for the in-flight request, and outputs return to reset values immediately (asynchronously).
- Backpressure: while `rsp_valid` is high and `rsp_ready` is low, no field of `rsp_*` may change.

## Configuration
- `ALU_SHARE_FIXED_PRIO_EN` defined: fixed priority. req0 always wins when both are valid, and `last_grant` is not implemented.
- Undefined (default): round-robin as described above.

## Test plan
- Single ADD: req0 a=5, b=7, op=000, funct7=0x00, tag=3. Response after 1 cycle with result 12, id 0, tag 3, err 0; `busy` high for 2 cycles.
- SUB and illegal op: req1 a=3, b=5, funct7=0x20 gives result 0xFFFFFFFE. A follow-up request with funct7=0x01 gives result 0 with `rsp_err`=1.
- Tie, round-robin: both requesters held valid for 4 transactions with `rsp_ready`=1. Grants go 0,1,0,1 and responses arrive every 2 cycles. With `ALU_SHARE_FIXED_PRIO_EN` defined, grants go 0,0,0,0.
- Backpressure: `rsp_ready`=0 for 5 cycles after an SLT with a=0xFFFFFFFF, b=1. `rsp_result`=1 is held stable and both readys stay 0 until release.
- Reset mid-op: pulse `rst_n` low during EXEC. `rsp_valid` never rises for that request, and the next request is granted to req0 on a tie.
- Shifts: SLL with a=1, b=0x21 gives 2. SRL with a=0x80000000, b=31 gives 1.
